// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: counters, registered syncs/data-enable,
// line/frame strobes and a completed-frame counter, advancing on pixel ticks.
module vga_timing_gen #(
    parameter int H_VISIBLE     = 640,
    parameter int H_FRONT_PORCH = 16,
    parameter int H_SYNC_PULSE  = 96,
    parameter int H_BACK_PORCH  = 48,
    parameter int V_VISIBLE     = 480,
    parameter int V_FRONT_PORCH = 10,
    parameter int V_SYNC_PULSE  = 2,
    parameter int V_BACK_PORCH  = 33,
    parameter bit HSYNC_POL     = 1'b0,
    parameter bit VSYNC_POL     = 1'b0,
    parameter int CNT_W         = 10,
    parameter int FRAME_W       = 8
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               ce,
    input  logic               en,
    output logic [CNT_W-1:0]   hc,
    output logic [CNT_W-1:0]   vc,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_count,
    output logic               running
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH;

    // Window bounds carry one extra bit so a sync ending exactly at 2^CNT_W still compares.
    localparam logic [CNT_W:0] H_VIS  = (CNT_W+1)'(H_VISIBLE);
    localparam logic [CNT_W:0] HS_BEG = (CNT_W+1)'(H_VISIBLE + H_FRONT_PORCH);
    localparam logic [CNT_W:0] HS_END = (CNT_W+1)'(H_VISIBLE + H_FRONT_PORCH + H_SYNC_PULSE);
    localparam logic [CNT_W:0] V_VIS  = (CNT_W+1)'(V_VISIBLE);
    localparam logic [CNT_W:0] VS_BEG = (CNT_W+1)'(V_VISIBLE + V_FRONT_PORCH);
    localparam logic [CNT_W:0] VS_END = (CNT_W+1)'(V_VISIBLE + V_FRONT_PORCH + V_SYNC_PULSE);

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] ZERO   = '0;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic             h_last;
    logic             v_last;
    logic [CNT_W-1:0] hc_nxt;
    logic [CNT_W-1:0] vc_nxt;

    function automatic logic in_win(input logic [CNT_W-1:0] p,
                                    input logic [CNT_W:0] lo,
                                    input logic [CNT_W:0] hi);
        return ({1'b0, p} >= lo) && ({1'b0, p} < hi);
    endfunction

    function automatic logic hs_level(input logic [CNT_W-1:0] h);
        return in_win(h, HS_BEG, HS_END) ? HSYNC_POL : ~HSYNC_POL;
    endfunction

    function automatic logic vs_level(input logic [CNT_W-1:0] v);
        return in_win(v, VS_BEG, VS_END) ? VSYNC_POL : ~VSYNC_POL;
    endfunction

    function automatic logic de_level(input logic [CNT_W-1:0] h, input logic [CNT_W-1:0] v);
        return ({1'b0, h} < H_VIS) && ({1'b0, v} < V_VIS);
    endfunction

    // NOTE: every signal assigned in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        h_last = (hc == H_LAST);
        v_last = (vc == V_LAST);
        hc_nxt = h_last ? '0 : hc + CNT_W'(1);
        vc_nxt = vc;
        if (h_last) begin
            vc_nxt = v_last ? '0 : vc + CNT_W'(1);
        end
    end

    // Syncs and de are registered from the next counter values, so they line up with hc/vc.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= IDLE;
            hc          <= '0;
            vc          <= '0;
            hsync       <= ~HSYNC_POL;
            vsync       <= ~VSYNC_POL;
            de          <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= '0;
            running     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (en && ce) begin
                        state       <= RUN;
                        hc          <= '0;
                        vc          <= '0;
                        hsync       <= hs_level(ZERO);
                        vsync       <= vs_level(ZERO);
                        de          <= de_level(ZERO, ZERO);
                        line_start  <= 1'b1;
                        frame_start <= 1'b1;
                        running     <= 1'b1;
                    end else begin
                        line_start  <= 1'b0;
                        frame_start <= 1'b0;
                    end
                end
                RUN: begin
                    if (!en) begin
                        state       <= IDLE;
                        hc          <= '0;
                        vc          <= '0;
                        hsync       <= ~HSYNC_POL;
                        vsync       <= ~VSYNC_POL;
                        de          <= 1'b0;
                        line_start  <= 1'b0;
                        frame_start <= 1'b0;
                        running     <= 1'b0;
                    end else if (ce) begin
                        hc          <= hc_nxt;
                        vc          <= vc_nxt;
                        hsync       <= hs_level(hc_nxt);
                        vsync       <= vs_level(vc_nxt);
                        de          <= de_level(hc_nxt, vc_nxt);
                        line_start  <= h_last;
                        frame_start <= h_last && v_last;
                        if (h_last && v_last) begin
                            frame_count <= frame_count + FRAME_W'(1);
                        end
                    end else begin
                        line_start  <= 1'b0;
                        frame_start <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Drives a default 640x480 instance and a small inverted-polarity instance in lockstep
// and compares both against a tick-count model of the raster.
module tb_vga_timing_gen;

    logic CLK = 1'b0;
    logic RESET = 1'b0;
    logic ce = 1'b0;
    logic en = 1'b0;

    always #5 CLK = ~CLK;

    logic [9:0] hc_o [2];
    logic [9:0] vc_o [2];
    logic       hs_o [2];
    logic       vs_o [2];
    logic       de_o [2];
    logic       ls_o [2];
    logic       fs_o [2];
    logic [7:0] fc_o [2];
    logic       run_o [2];

    vga_timing_gen dut_d (
        .CLK(CLK), .RESET(RESET), .ce(ce), .en(en),
        .hc(hc_o[0]), .vc(vc_o[0]), .hsync(hs_o[0]), .vsync(vs_o[0]), .de(de_o[0]),
        .line_start(ls_o[0]), .frame_start(fs_o[0]), .frame_count(fc_o[0]), .running(run_o[0])
    );

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT_PORCH(2), .H_SYNC_PULSE(3), .H_BACK_PORCH(1),
        .V_VISIBLE(4), .V_FRONT_PORCH(1), .V_SYNC_PULSE(1), .V_BACK_PORCH(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
    ) dut_s (
        .CLK(CLK), .RESET(RESET), .ce(ce), .en(en),
        .hc(hc_o[1]), .vc(vc_o[1]), .hsync(hs_o[1]), .vsync(vs_o[1]), .de(de_o[1]),
        .line_start(ls_o[1]), .frame_start(fs_o[1]), .frame_count(fc_o[1]), .running(run_o[1])
    );

    // Timing of each instance: visible, front porch, sync, back porch; then polarity.
    localparam int HV [2] = '{640, 8};
    localparam int HF [2] = '{16, 2};
    localparam int HS [2] = '{96, 3};
    localparam int HB [2] = '{48, 1};
    localparam int VV [2] = '{480, 4};
    localparam int VF [2] = '{10, 1};
    localparam int VS [2] = '{2, 1};
    localparam int VB [2] = '{33, 1};
    localparam bit POL [2] = '{1'b0, 1'b1};

    // Model: a running flag, ticks since start, and frames banked before the last stop.
    bit     m_run  [2];
    longint m_k    [2];
    longint m_fb   [2];
    bit     m_tick [2];

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_update(input bit r, input bit e, input bit c);
        for (int i = 0; i < 2; i++) begin
            longint frame_len;
            frame_len = longint'(HV[i] + HF[i] + HS[i] + HB[i]) * (VV[i] + VF[i] + VS[i] + VB[i]);
            m_tick[i] = 1'b0;
            if (r) begin
                m_run[i] = 1'b0;
                m_k[i]   = 0;
                m_fb[i]  = 0;
            end else if (!m_run[i]) begin
                if (e && c) begin
                    m_run[i]  = 1'b1;
                    m_k[i]    = 0;
                    m_tick[i] = 1'b1;
                end
            end else if (!e) begin
                m_fb[i]  = m_fb[i] + m_k[i] / frame_len;
                m_k[i]   = 0;
                m_run[i] = 1'b0;
            end else if (c) begin
                m_k[i]    = m_k[i] + 1;
                m_tick[i] = 1'b1;
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            int     ht, vt, h, v;
            longint frames;
            bit     e_hs, e_vs, e_de, e_ls, e_fs;
            string  p;
            p  = (i == 0) ? "dflt" : "small";
            ht = HV[i] + HF[i] + HS[i] + HB[i];
            vt = VV[i] + VF[i] + VS[i] + VB[i];
            h  = 0;
            v  = 0;
            frames = m_fb[i];
            e_hs = ~POL[i];
            e_vs = ~POL[i];
            e_de = 1'b0;
            e_ls = 1'b0;
            e_fs = 1'b0;
            if (m_run[i]) begin
                h = int'(m_k[i] % ht);
                v = int'((m_k[i] / ht) % vt);
                frames = m_fb[i] + m_k[i] / (longint'(ht) * vt);
                if (h >= HV[i] + HF[i] && h < HV[i] + HF[i] + HS[i]) e_hs = POL[i];
                if (v >= VV[i] + VF[i] && v < VV[i] + VF[i] + VS[i]) e_vs = POL[i];
                e_de = (h < HV[i]) && (v < VV[i]);
                e_ls = m_tick[i] && (h == 0);
                e_fs = m_tick[i] && (h == 0) && (v == 0);
            end
            check({p, ".hc"}, longint'(hc_o[i]), h);
            check({p, ".vc"}, longint'(vc_o[i]), v);
            check({p, ".hsync"}, longint'(hs_o[i]), longint'(e_hs));
            check({p, ".vsync"}, longint'(vs_o[i]), longint'(e_vs));
            check({p, ".de"}, longint'(de_o[i]), longint'(e_de));
            check({p, ".line_start"}, longint'(ls_o[i]), longint'(e_ls));
            check({p, ".frame_start"}, longint'(fs_o[i]), longint'(e_fs));
            check({p, ".frame_count"}, longint'(fc_o[i]), frames % 256);
            check({p, ".running"}, longint'(run_o[i]), longint'(m_run[i]));
        end
    endtask

    task automatic step(input bit r, input bit e, input bit c);
        @(negedge CLK);
        RESET = r;
        en    = e;
        ce    = c;
        @(posedge CLK);
        model_update(r, e, c);
        #1;
        compare_all();
    endtask

    initial begin
        // Reset, then idle with en low or ce low.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);

        // Continuous ticks: several default lines, many small frames.
        for (int i = 0; i < 2500; i++) step(1'b0, 1'b1, 1'b1);

        // One tick every fourth clock.
        for (int i = 0; i < 3400; i++) step(1'b0, 1'b1, (i % 4) == 3);

        // Stop mid-line, idle, then restart.
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 900; i++) step(1'b0, 1'b1, 1'b1);

        // Reset while running, then re-entry with en held high.
        step(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 300; i++) step(1'b0, 1'b1, 1'b1);

        // Random ce, occasional en drop and rare reset.
        for (int i = 0; i < 8000; i++) begin
            bit r, e, c;
            r = ($urandom_range(0, 2999) == 0);
            e = ($urandom_range(0, 249) != 0);
            c = ($urandom_range(0, 2) != 0);
            step(r, e, c);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised raster timing generator; next generation of the fixed 640x480 VGA initializer. All porch/sync/visible widths and sync polarities are parameters. Adds a pixel clock-enable, a run/stop control, registered (glitch-free) sync and data-enable outputs, line/frame strobes and a frame counter. Drives the VGA pins directly and supplies pixel coordinates and strobes to the game renderer.

Parameters:
H_VISIBLE, 640, active pixels per line
H_FRONT_PORCH, 16, pixels between active video and hsync
H_SYNC_PULSE, 96, hsync width in pixels
H_BACK_PORCH, 48, pixels after hsync
V_VISIBLE, 480, active lines per frame
V_FRONT_PORCH, 10, lines between active video and vsync
V_SYNC_PULSE, 2, vsync width in lines
V_BACK_PORCH, 33, lines after vsync
HSYNC_POL, 0, active level of hsync (0 = active-low)
VSYNC_POL, 0, active level of vsync
CNT_W, 10, width of hc/vc; must satisfy 2^CNT_W >= H_TOTAL and 2^CNT_W >= V_TOTAL
FRAME_W, 8, width of frame_count
Derived localparams: H_TOTAL = sum of H_*; V_TOTAL = sum of V_*.

Ports:
CLK  input  1  system clock
RESET  input  1  synchronous, active-high reset
ce  input  1  pixel tick enable; the timing advances only on CLK edges with ce=1
en  input  1  run request; 0 stops the raster
hc  output  CNT_W  horizontal position, 0..H_TOTAL-1
vc  output  CNT_W  vertical position, 0..V_TOTAL-1
hsync  output  1  registered horizontal sync, polarity HSYNC_POL
vsync  output  1  registered vertical sync, polarity VSYNC_POL
de  output  1  registered data enable, high when hc<H_VISIBLE and vc<V_VISIBLE
line_start  output  1  one-CLK pulse when hc becomes 0
frame_start  output  1  one-CLK pulse when (hc,vc) becomes (0,0)
frame_count  output  FRAME_W  completed-frame counter
running  output  1  state indicator (1 = RUN)

Behaviour:
- One clock, CLK only. RESET is synchronous and active-high, with priority over everything else.
- Reset values: state=IDLE, hc=0, vc=0, hsync=~HSYNC_POL, vsync=~VSYNC_POL, de=0, line_start=0, frame_start=0, frame_count=0, running=0.
- Define f(h,v):
  - hsync active iff H_VISIBLE+H_FRONT_PORCH <= h < H_VISIBLE+H_FRONT_PORCH+H_SYNC_PULSE.
  - vsync active iff the same window rule holds for v using the V_* parameters.
  - de = (h<H_VISIBLE && v<V_VISIBLE).
- hsync, vsync and de are registered and always equal f(hc,vc) of the same cycle while in RUN. They are computed from next-state counter values, so they have zero latency relative to hc/vc.
- State IDLE:
  - Counters are held at 0 and outputs stay at their idle/reset levels.
  - On an edge with en=1 and ce=1: go to RUN. hc and vc stay 0; outputs become f(0,0); line_start=1; frame_start=1; running=1.
  - en=1 with ce=0 stays in IDLE.
- State RUN, edge with ce=1:
  - If hc==H_TOTAL-1: hc wraps to 0 and line_start=1. Otherwise hc increments.
  - On an hc wrap, if vc==V_TOTAL-1: vc wraps to 0, frame_start=1 and frame_count increments (modulo 2^FRAME_W). Otherwise vc increments.
  - Outputs take f of the new counters.
- State RUN, edge with ce=0: counters, syncs and de hold; line_start and frame_start drop to 0. Strobes are exactly one CLK wide regardless of the ce duty cycle.
- State RUN, edge with en=0 (ce is don't-care): go to IDLE. Counters go to 0, outputs go to idle levels, running=0. frame_count is retained and cleared only by RESET.
- RESET mid-frame: the next edge yields the full reset values; the raster restarts from (0,0) only through the IDLE->RUN entry.
- The first frame after start is frame 0. frame_count counts completed frames and does not increment on the IDLE->RUN entry.
- No combinational path from any input to any output.

Test Plan:
- Default parameters, RESET pulse then en=1, ce=1 constant:
  - First RUN cycle shows hc=0, vc=0, de=1, line_start=1, frame_start=1.
  - hsync is low exactly for hc 656..751, i.e. 96 cycles per line.
  - vsync is low for vc 490..491.
  - Line period is 800 cycles; frame period is 420000 cycles.
- Wrap: run until hc=799, vc=524. The next ce edge gives hc=0, vc=0, frame_start=1, frame_count=1. de is 0 for hc 640..799 and for vc 480..524.
- ce=1 every 4th CLK: hc advances once per 4 CLK. Each line_start is exactly 1 CLK wide. Line period is 3200 CLK.
- Polarity override HSYNC_POL=1, VSYNC_POL=1, small timing (H 8/2/3/1, V 4/1/1/1):
  - hsync is high only at hc 10..12; vsync is high only at vc 5.
  - H_TOTAL=14, V_TOTAL=7, i.e. 98 ce ticks per frame.
- Drop en at hc=300, vc=100: the next edge gives IDLE, hc=0, vc=0, de=0, hsync=1, running=0, with frame_count unchanged. Re-assert en: restart with frame_start=1.
- Assert RESET at hc=500 with en=1: the next edge gives all reset values including frame_count=0. The edge after that (RESET low) re-enters RUN at (0,0).
